muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
- Multicycle sequencer for the MULT and DIV instructions, with signed 32-bit operands.
- Driven by the main control unit: it pulses start, waits on busy/done, then continues.
- Runs an iterative shift-add multiplier or a restoring divider over WIDTH cycles and writes the HI/LO registers it owns.
- Flags divide-by-zero to the exception logic.

Parameters:
WIDTH, 32, operand width; iteration count equals WIDTH.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-low reset.
start  input  1  request; sampled only in IDLE.
op  input  1  0 = MULT, 1 = DIV.
A  input  WIDTH  multiplicand / dividend (signed), captured at start.
B  input  WIDTH  multiplier / divisor (signed), captured at start.
busy  output  1  high in every state except IDLE.
done  output  1  one-cycle pulse: result valid, or op aborted.
div_zero  output  1  one-cycle pulse coincident with done; DIV with B == 0.
HI  output  WIDTH  MULT: product[63:32]; DIV: remainder.
LO  output  WIDTH  MULT: product[31:0]; DIV: quotient.

Behaviour:

Reset (reset == 0 at a rising edge):
- State becomes IDLE. busy = 0, done = 0, div_zero = 0, HI = 0, LO = 0, iteration counter = 0.
- Applies mid-operation too: the op is abandoned, no done is issued, and HI/LO are cleared.

States: IDLE, PREP, MULT_LOOP, DIV_LOOP, FIX_SIGN, DONE.
- IDLE: on start = 1, latch op, A and B, then go to PREP. start in any other state is ignored.
- PREP: take magnitudes |A| and |B| as unsigned WIDTH-bit values (|-2^31| = 0x80000000). Record sign_q = A[msb] ^ B[msb] and sign_r = A[msb]. Clear the accumulator and counter.
  - DIV with B == 0 → go to DONE with div_zero set; HI/LO stay unchanged.
  - Otherwise MULT → MULT_LOOP, DIV → DIV_LOOP.
- MULT_LOOP: one iteration per cycle, exactly WIDTH cycles, over a 2*WIDTH product register.
  - If multiplier LSB = 1, add the multiplicand to the upper half with carry kept.
  - Then shift right by 1. After WIDTH iterations → FIX_SIGN.
- DIV_LOOP: restoring division, one quotient bit per cycle, exactly WIDTH cycles.
  - Shift {rem, quot} left by 1 and trial-subtract the divisor from rem.
  - If the result is non-negative, keep it and set quot LSB = 1; otherwise restore.
  - After WIDTH iterations → FIX_SIGN.
- FIX_SIGN:
  - MULT: two's-complement negate the full 2*WIDTH product if sign_q.
  - DIV: negate the quotient if sign_q; negate the remainder if sign_r (remainder takes the dividend's sign).
  - Then go to DONE.
- DONE: HI/LO are loaded on the edge entering DONE. done = 1 for this single cycle (div_zero = 1 as well if applicable). Next state is IDLE.

Timing (edge E0 is the one that samples start):
- Normal op: done is high in the cycle following edge E(WIDTH+3), i.e. E35 for WIDTH = 32.
- Divide-by-zero: done is high after E2.
- A new start is accepted in the cycle right after done, so back-to-back ops are gap-free apart from that IDLE cycle.

Output and input rules:
- HI/LO hold their value between ops; they change only on entry to DONE or on reset.
- Changes on A, B or op after E0 have no effect.

Arithmetic corner cases:
- MULT (-2^31) × (-2^31) → HI = 0x40000000, LO = 0.
- DIV (-2^31) / (-1) → LO = 0x80000000, HI = 0, no div_zero.
- Result is exact for all other operand pairs, and truncates toward zero.

Test Plan:
- MULT A = 7, B = -3 (0xFFFFFFFD): start at E0 → busy = 1 from E0; done after E35 with HI = 0xFFFFFFFF, LO = 0xFFFFFFEB; busy = 0 after E36.
- DIV A = -7, B = 2: → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF, done after E35, div_zero = 0.
- DIV A = 5, B = 0, with prior HI = 0x11, LO = 0x22: → done and div_zero both high after E2 for one cycle; HI = 0x11, LO = 0x22 unchanged.
- MULT A = 0x80000000, B = 0x80000000 → HI = 0x40000000, LO = 0; and DIV A = 0x80000000, B = 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- Start a MULT, hold reset = 0 at E10 → busy = 0 and HI = LO = 0 after E10; no done pulse within the next 40 cycles.
- Pulse start again at E5 during an op with A = 1, B = 1 → ignored; the first result completes at E35. Start at the IDLE cycle right after done → second result arrives 35 edges later.

Source files
------------

// File: rtl/muldiv_seq.sv
// Multicycle MULT/DIV sequencer: iterative shift-add multiplier and restoring
// divider on signed operands, owning the HI/LO result registers.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    typedef enum logic [2:0] {
        S_IDLE, S_PREP, S_MULT_LOOP, S_DIV_LOOP, S_FIX_SIGN, S_DONE
    } state_t;

    localparam int              CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    state_t               state_q, state_d;
    logic                 op_q;
    logic [WIDTH-1:0]     a_q, b_q;
    logic [WIDTH-1:0]     opnd_q;       // multiplicand (MULT) or divisor (DIV)
    logic [2*WIDTH-1:0]   prod_q;       // MULT: product; DIV: {rem, quot}
    logic [CW-1:0]        cnt_q;
    logic                 neg_quot_q, neg_rem_q, dz_q;
    logic [WIDTH-1:0]     hi_q, lo_q;

    // Operand magnitudes; -2^(W-1) maps onto itself, read back as unsigned.
    logic [WIDTH-1:0]     mag_a, mag_b;
    assign mag_a = a_q[WIDTH-1] ? -a_q : a_q;
    assign mag_b = b_q[WIDTH-1] ? -b_q : b_q;

    // One shift-add step: add multiplicand into the upper half, keep carry, shift right.
    logic [WIDTH:0]       mult_sum;
    logic [2*WIDTH-1:0]   mult_next;
    assign mult_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
    assign mult_next = prod_q[0] ? {mult_sum, prod_q[WIDTH-1:1]}
                                 : {1'b0, prod_q[2*WIDTH-1:1]};

    // One restoring step: shift {rem, quot} left, trial-subtract; the msb of the
    // W+1 bit difference is the borrow because rem_sh < 2 * divisor.
    logic [WIDTH:0]       rem_sh, trial;
    logic [2*WIDTH-1:0]   div_next;
    assign rem_sh   = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
    assign trial    = rem_sh - {1'b0, opnd_q};
    assign div_next = trial[WIDTH] ? {rem_sh[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0}
                                   : {trial[WIDTH-1:0],  prod_q[WIDTH-2:0], 1'b1};

    // Sign-corrected results written into HI/LO on the way into DONE.
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quot_fix, rem_fix;
    assign prod_fix = neg_quot_q ? -prod_q : prod_q;
    assign quot_fix = neg_quot_q ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];
    assign rem_fix  = neg_rem_q  ? -prod_q[2*WIDTH-1:WIDTH] : prod_q[2*WIDTH-1:WIDTH];

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: registers are written with <= so every flop samples pre-edge values.
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic. PREP spends two cycles: the first registers the
    // magnitudes, the second tests the registered divisor for zero.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (start) state_d = S_PREP;
            S_PREP: begin
                if (cnt_q != '0) begin
                    if (op_q && opnd_q == '0) state_d = S_DONE;
                    else if (op_q)            state_d = S_DIV_LOOP;
                    else                      state_d = S_MULT_LOOP;
                end
            end
            S_MULT_LOOP,
            S_DIV_LOOP:  if (cnt_q == LAST) state_d = S_FIX_SIGN;
            S_FIX_SIGN:  state_d = S_DONE;
            S_DONE:      state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Status and result outputs decoded from state and held registers.
    always_comb begin
        busy     = (state_q != S_IDLE);
        done     = (state_q == S_DONE);
        div_zero = (state_q == S_DONE) && dz_q;
        HI       = hi_q;
        LO       = lo_q;
    end

    // Datapath: operand capture, iteration, sign fix-up and HI/LO update.
    always_ff @(posedge clk) begin
        if (!reset) begin
            op_q       <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            opnd_q     <= '0;
            prod_q     <= '0;
            cnt_q      <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            dz_q       <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_q  <= op;
                        a_q   <= A;
                        b_q   <= B;
                        cnt_q <= '0;
                        dz_q  <= 1'b0;
                    end
                end
                S_PREP: begin
                    if (cnt_q == '0) begin
                        neg_quot_q <= a_q[WIDTH-1] ^ b_q[WIDTH-1];
                        neg_rem_q  <= a_q[WIDTH-1];
                        opnd_q     <= op_q ? mag_b : mag_a;
                        prod_q     <= {{WIDTH{1'b0}}, (op_q ? mag_a : mag_b)};
                        cnt_q      <= CW'(1);
                    end else begin
                        dz_q  <= op_q && (opnd_q == '0);
                        cnt_q <= '0;
                    end
                end
                S_MULT_LOOP: begin
                    prod_q <= mult_next;
                    cnt_q  <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
                end
                S_DIV_LOOP: begin
                    prod_q <= div_next;
                    cnt_q  <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
                end
                S_FIX_SIGN: begin
                    if (op_q) begin
                        hi_q <= rem_fix;
                        lo_q <= quot_fix;
                    end else begin
                        hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_q <= prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed corner cases plus random
// MULT/DIV operations compared against 64-bit signed arithmetic.
module tb_muldiv_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, start, op;
    logic [W-1:0] A, B;
    logic         busy, done, div_zero;
    logic [W-1:0] HI, LO;

    int vectors     = 0;
    int miscompares = 0;

    logic [W-1:0] exp_hi = '0;
    logic [W-1:0] exp_lo = '0;

    muldiv_seq #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
        .busy(busy), .done(done), .div_zero(div_zero), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain signed 64-bit arithmetic; SV division truncates toward
    // zero and the remainder takes the dividend's sign.
    task automatic model(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic dz);
        longint     sa, sb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        dz = 1'b0;
        if (!o) begin
            p      = 64'(sa * sb);
            exp_hi = p[63:32];
            exp_lo = p[31:0];
        end else if (b == '0) begin
            dz = 1'b1;
        end else begin
            p      = 64'(sa / sb);
            exp_lo = p[31:0];
            p      = 64'(sa % sb);
            exp_hi = p[31:0];
        end
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h0000_0000;
            3:       return 32'h0000_0001;
            default: return W'($urandom);
        endcase
    endfunction

    // One complete operation; poke re-pulses start mid-op to check it is ignored.
    task automatic run_op(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit poke);
        int   n;
        logic dz;
        model(o, a, b, dz);
        op = o; A = a; B = b; start = 1'b1;
        tick();                               // E0
        start = 1'b0; op = ~o; A = W'($urandom); B = W'($urandom);
        chk("busy_after_start", 64'(busy), 64'd1);
        n = 0;
        while (n < 60) begin
            if (poke && n == 4) begin
                start = 1'b1; A = 32'd1; B = 32'd1; op = 1'b0;
            end else begin
                start = 1'b0;
            end
            tick();
            n++;
            if (done) break;
            chk("busy_in_flight", 64'(busy), 64'd1);
        end
        start = 1'b0;
        chk("done_latency", 64'(n), 64'(dz ? 2 : W + 3));
        chk("div_zero", 64'(div_zero), 64'(dz));
        chk("HI", 64'(HI), 64'(exp_hi));
        chk("LO", 64'(LO), 64'(exp_lo));
        tick();
        chk("done_single_cycle", 64'(done), 64'd0);
        chk("busy_back_to_idle", 64'(busy), 64'd0);
        chk("HI_hold", 64'(HI), 64'(exp_hi));
        chk("LO_hold", 64'(LO), 64'(exp_lo));
    endtask

    initial begin
        logic seen_done;
        reset = 1'b0; start = 1'b0; op = 1'b0; A = '0; B = '0;
        repeat (3) tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_div_zero", 64'(div_zero), 64'd0);
        chk("rst_HI", 64'(HI), 64'd0);
        chk("rst_LO", 64'(LO), 64'd0);
        reset = 1'b1;
        tick();

        // Directed cases.
        run_op(1'b0, 32'd7, 32'hFFFF_FFFD, 1'b0);           // MULT 7 * -3
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);           // DIV -7 / 2
        run_op(1'b1, 32'h0000_0451, 32'h0000_0020, 1'b0);   // HI=0x11, LO=0x22
        chk("prior_HI", 64'(HI), 64'h11);
        chk("prior_LO", 64'(LO), 64'h22);
        run_op(1'b1, 32'd5, 32'd0, 1'b0);                   // divide by zero
        chk("dz_HI_kept", 64'(HI), 64'h11);
        chk("dz_LO_kept", 64'(LO), 64'h22);
        run_op(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0);
        chk("min_sq_HI", 64'(HI), 64'h4000_0000);
        chk("min_sq_LO", 64'(LO), 64'h0);
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        chk("min_div_m1_LO", 64'(LO), 64'h8000_0000);
        chk("min_div_m1_HI", 64'(HI), 64'h0);
        run_op(1'b1, 32'd1000, 32'hFFFF_FFF9, 1'b1);        // stray start at E5
        run_op(1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);   // back-to-back

        // Reset in the middle of a MULT.
        op = 1'b0; A = 32'd12345; B = 32'd678; start = 1'b1;
        tick();                                             // E0
        start = 1'b0;
        repeat (9) tick();                                  // E9
        reset = 1'b0;
        tick();                                             // E10
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_HI", 64'(HI), 64'd0);
        chk("midrst_LO", 64'(LO), 64'd0);
        exp_hi = '0;
        exp_lo = '0;
        reset = 1'b1;
        seen_done = 1'b0;
        repeat (40) begin
            tick();
            if (done) seen_done = 1'b1;
        end
        chk("midrst_no_done", 64'(seen_done), 64'd0);

        // Random operations with corner-biased operands.
        for (int i = 0; i < 40; i++) begin
            logic         o;
            logic [W-1:0] a, b;
            o = 1'($urandom_range(0, 1));
            a = pick();
            b = pick();
            run_op(o, a, b, ($urandom_range(0, 7) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
